// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle RV32I control sequencer
// Optional performance counters are built when PERF_COUNTERS_EN is defined.
module multicycle_ctrl_fsm #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic              bcond,
  input  logic              halt_cond,
  input  logic              mem_ready,
  output logic              pc_write_final,
  output logic              ir_write,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              aluout_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              is_halted,
  output logic [2:0]        state,
  output logic [PERF_W-1:0] cycle_count,
  output logic [PERF_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BRCMP = 2'b01;
  localparam logic [1:0] ALU_RFN   = 2'b10;
  localparam logic [1:0] ALU_IFN   = 2'b11;

  state_t r_state;
  state_t w_next_state;
  logic   r_taken;
  logic   w_taken_next;
  logic   w_is_load;
  logic   w_is_store;

  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_taken <= w_taken_next;
    end
  end

  always_comb begin
    w_next_state   = S_IF;
    w_taken_next   = r_taken;
    pc_write_final = 1'b0;
    ir_write       = 1'b0;
    i_or_d         = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write      = 1'b0;
    aluout_write   = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = SRCB_REG;
    alu_op         = ALU_ADD;

    // Reset drops every request immediately, abandoning any memory access.
    if (!reset) begin
      case (r_state)
        S_IF: begin
          mem_read     = 1'b1;
          ir_write     = mem_ready;
          w_next_state = mem_ready ? S_ID : S_IF;
        end

        S_ID: begin
          alu_src_b    = SRCB_FOUR;
          aluout_write = 1'b1;
          w_next_state = ((opcode == OP_ECALL) && halt_cond) ? S_HALT : S_EX;
        end

        S_EX: begin
          case (opcode)
            OP_RTYPE: begin
              alu_src_a    = 1'b1;
              alu_op       = ALU_RFN;
              aluout_write = 1'b1;
              w_next_state = S_WB;
            end
            OP_IALU: begin
              alu_src_a    = 1'b1;
              alu_src_b    = SRCB_IMM;
              alu_op       = ALU_IFN;
              aluout_write = 1'b1;
              w_next_state = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a    = 1'b1;
              alu_src_b    = SRCB_IMM;
              aluout_write = 1'b1;
              w_next_state = S_MEM;
            end
            OP_BRANCH: begin
              alu_src_a    = 1'b1;
              alu_op       = ALU_BRCMP;
              w_taken_next = bcond;
              w_next_state = S_BR;
            end
            // ALUOut keeps PC+4 from decode so rd receives the link address.
            OP_JAL, OP_JALR: begin
              alu_src_a      = (opcode == OP_JALR);
              alu_src_b      = SRCB_IMM;
              pc_write_final = 1'b1;
              reg_write      = 1'b1;
              w_next_state   = S_IF;
            end
            default: begin
              w_taken_next = 1'b0;
              w_next_state = S_BR;
            end
          endcase
        end

        S_MEM: begin
          i_or_d = 1'b1;
          if (w_is_store) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              alu_src_b      = SRCB_FOUR;
              pc_write_final = 1'b1;
              w_next_state   = S_IF;
            end else begin
              w_next_state = S_MEM;
            end
          end else if (w_is_load) begin
            mem_read     = 1'b1;
            w_next_state = mem_ready ? S_WB : S_MEM;
          end else begin
            w_next_state = S_IF;
          end
        end

        S_WB: begin
          reg_write      = 1'b1;
          mem_to_reg     = w_is_load;
          alu_src_b      = SRCB_FOUR;
          pc_write_final = 1'b1;
          w_next_state   = S_IF;
        end

        S_BR: begin
          alu_src_b      = r_taken ? SRCB_IMM : SRCB_FOUR;
          pc_write_final = 1'b1;
          w_next_state   = S_IF;
        end

        S_HALT: begin
          w_next_state = S_HALT;
        end

        default: begin
          w_next_state = S_IF;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign is_halted = (r_state == S_HALT);

`ifdef PERF_COUNTERS_EN
  logic [PERF_W-1:0] r_cycle_count;
  logic [PERF_W-1:0] r_instret_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else if (r_state != S_HALT) begin
      r_cycle_count <= r_cycle_count + PERF_W'(1);
      if (pc_write_final) begin
        r_instret_count <= r_instret_count + PERF_W'(1);
      end
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - bench for multicycle_ctrl_fsm
// Expected traces are generated per instruction class; PERF_COUNTERS_EN selects counter checks.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_EC  = 7'b1110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [7:0] P_PCW = 8'h80;
  localparam logic [7:0] P_IRW = 8'h40;
  localparam logic [7:0] P_IOD = 8'h20;
  localparam logic [7:0] P_MRD = 8'h10;
  localparam logic [7:0] P_MWR = 8'h08;
  localparam logic [7:0] P_M2R = 8'h04;
  localparam logic [7:0] P_RW  = 8'h02;
  localparam logic [7:0] P_AOW = 8'h01;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        bcond, halt_cond, mem_ready;
  logic        pc_write_final, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_write, aluout_write, alu_src_a, is_halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [2:0]  state;
  logic [31:0] cycle_count, instret_count;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
    .halt_cond(halt_cond), .mem_ready(mem_ready),
    .pc_write_final(pc_write_final), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .aluout_write(aluout_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted),
    .state(state), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        bc;
    logic        hc;
    logic        mr;
    logic [16:0] exp;
  } vec_t;

  vec_t        tbl [6];
  vec_t        q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] e_cyc = 0;
  logic [31:0] e_ins = 0;
  string       label;

  function automatic logic [16:0] ex(input logic [2:0] st, input logic [7:0] strb,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic hlt);
    return {st, strb, asa, asb, aop, hlt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic [6:0] op, input logic bc,
                      input logic hc, input logic mr, input logic [16:0] e);
    vec_t v;
    v.rst = rst; v.op = op; v.bc = bc; v.hc = hc; v.mr = mr; v.exp = e;
    q.push_back(v);
  endtask

  task automatic push_wb(input logic [6:0] op, input logic m2r);
    push(0, op, rb(), rb(), rb(), ex(4, P_PCW | P_RW | (m2r ? P_M2R : 8'h00), 0, 2'b01, 2'b00, 0));
  endtask

  // Expected cycle trace of one instruction, derived from its class.
  task automatic gen_instr(input logic [6:0] op, input logic bc, input logic hc,
                           input int if_w, input int mem_w);
    for (int k = 0; k < if_w; k++) push(0, op, rb(), rb(), 0, ex(0, P_MRD, 0, 2'b00, 2'b00, 0));
    push(0, op, rb(), rb(), 1, ex(0, P_MRD | P_IRW, 0, 2'b00, 2'b00, 0));
    push(0, op, rb(), hc, rb(), ex(1, P_AOW, 0, 2'b01, 2'b00, 0));
    if (op == OP_EC && hc) return;
    case (op)
      OP_R: begin
        push(0, op, rb(), rb(), rb(), ex(2, P_AOW, 1, 2'b00, 2'b10, 0));
        push_wb(op, 0);
      end
      OP_I: begin
        push(0, op, rb(), rb(), rb(), ex(2, P_AOW, 1, 2'b10, 2'b11, 0));
        push_wb(op, 0);
      end
      OP_LD, OP_ST: begin
        logic [7:0] acc;
        acc = P_IOD | ((op == OP_LD) ? P_MRD : P_MWR);
        push(0, op, rb(), rb(), rb(), ex(2, P_AOW, 1, 2'b10, 2'b00, 0));
        for (int k = 0; k < mem_w; k++) push(0, op, rb(), rb(), 0, ex(3, acc, 0, 2'b00, 2'b00, 0));
        if (op == OP_LD) begin
          push(0, op, rb(), rb(), 1, ex(3, acc, 0, 2'b00, 2'b00, 0));
          push_wb(op, 1);
        end else begin
          push(0, op, rb(), rb(), 1, ex(3, acc | P_PCW, 0, 2'b01, 2'b00, 0));
        end
      end
      OP_BR: begin
        push(0, op, bc, rb(), rb(), ex(2, 8'h00, 1, 2'b00, 2'b01, 0));
        push(0, op, rb(), rb(), rb(), ex(5, P_PCW, 0, bc ? 2'b10 : 2'b01, 2'b00, 0));
      end
      OP_JAL, OP_JR: begin
        push(0, op, rb(), rb(), rb(), ex(2, P_PCW | P_RW, (op == OP_JR), 2'b10, 2'b00, 0));
      end
      default: begin
        push(0, op, rb(), rb(), rb(), ex(2, 8'h00, 0, 2'b00, 2'b00, 0));
        push(0, op, rb(), rb(), rb(), ex(5, P_PCW, 0, 2'b01, 2'b00, 0));
      end
    endcase
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [16:0] got;
    reset = v.rst; opcode = v.op; bcond = v.bc; halt_cond = v.hc; mem_ready = v.mr;
    @(negedge clk);
    got = {state, pc_write_final, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_write, aluout_write, alu_src_a, alu_src_b, alu_op, is_halted};
    n_cmp++;
    if (got !== v.exp) begin
      n_fail++;
      $display("FAIL %s[%0d] outputs: got %h expected %h", label, idx, got, v.exp);
    end
    n_cmp++;
    if (cycle_count !== e_cyc || instret_count !== e_ins) begin
      n_fail++;
      $display("FAIL %s[%0d] counters: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
               label, idx, cycle_count, instret_count, e_cyc, e_ins);
    end
    @(posedge clk);
    #1;
`ifdef PERF_COUNTERS_EN
    if (v.rst) begin
      e_cyc = 0;
      e_ins = 0;
    end else if (v.exp[16:14] != 3'd6) begin
      e_cyc = e_cyc + 1;
      if (v.exp[13]) e_ins = e_ins + 1;
    end
`endif
  endtask

  task automatic run_q(input string name);
    label = name;
    for (int i = 0; i < q.size(); i++) apply(q[i], i);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rop;
    reset = 1; opcode = OP_R; bcond = 0; halt_cond = 0; mem_ready = 0;
    @(posedge clk);
    #1;

    tbl[0] = '{1'b1, OP_R, 1'b0, 1'b0, 1'b1, ex(0, 8'h00, 0, 2'b00, 2'b00, 0)};
    tbl[1] = '{1'b0, OP_R, 1'b0, 1'b0, 1'b1, ex(0, P_MRD | P_IRW, 0, 2'b00, 2'b00, 0)};
    tbl[2] = '{1'b0, OP_R, 1'b0, 1'b0, 1'b1, ex(1, P_AOW, 0, 2'b01, 2'b00, 0)};
    tbl[3] = '{1'b0, OP_R, 1'b0, 1'b0, 1'b1, ex(2, P_AOW, 1, 2'b00, 2'b10, 0)};
    tbl[4] = '{1'b0, OP_R, 1'b0, 1'b0, 1'b1, ex(4, P_PCW | P_RW, 0, 2'b01, 2'b00, 0)};
    tbl[5] = '{1'b0, OP_R, 1'b0, 1'b0, 1'b0, ex(0, P_MRD, 0, 2'b00, 2'b00, 0)};
    label = "add_table";
    for (int i = 0; i < 6; i++) apply(tbl[i], i);

    gen_instr(OP_LD, 0, 0, 3, 3);
    run_q("load_wait");
    gen_instr(OP_BR, 1, 0, 0, 0);
    gen_instr(OP_BR, 0, 0, 0, 0);
    run_q("beq_pair");
    gen_instr(OP_JAL, 0, 0, 0, 0);
    gen_instr(OP_JR, 0, 0, 1, 0);
    gen_instr(OP_ST, 0, 0, 0, 2);
    gen_instr(OP_EC, 0, 0, 0, 0);
    run_q("jumps_store");

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 8))
        0: rop = OP_R;   1: rop = OP_I;  2: rop = OP_LD;  3: rop = OP_ST;
        4: rop = OP_BR;  5: rop = OP_JAL; 6: rop = OP_JR; 7: rop = OP_EC;
        default: rop = OP_LUI;
      endcase
      gen_instr(rop, rb(), (rop == OP_EC) ? 1'b0 : rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_q("random");

    gen_instr(OP_EC, 0, 1, 1, 0);
    for (int k = 0; k < 20; k++)
      push(0, 7'($urandom_range(0, 127)), rb(), rb(), rb(), ex(6, 8'h00, 0, 2'b00, 2'b00, 1));
    push(1, OP_EC, rb(), rb(), rb(), ex(6, 8'h00, 0, 2'b00, 2'b00, 1));
    push(0, OP_R, rb(), rb(), 0, ex(0, P_MRD, 0, 2'b00, 2'b00, 0));
    gen_instr(OP_I, 0, 0, 0, 0);
    run_q("halt");

    push(0, OP_ST, rb(), rb(), 1, ex(0, P_MRD | P_IRW, 0, 2'b00, 2'b00, 0));
    push(0, OP_ST, rb(), rb(), rb(), ex(1, P_AOW, 0, 2'b01, 2'b00, 0));
    push(0, OP_ST, rb(), rb(), rb(), ex(2, P_AOW, 1, 2'b10, 2'b00, 0));
    push(0, OP_ST, rb(), rb(), 0, ex(3, P_IOD | P_MWR, 0, 2'b00, 2'b00, 0));
    push(1, OP_ST, rb(), rb(), 0, ex(3, 8'h00, 0, 2'b00, 2'b00, 0));
    push(0, OP_ST, rb(), rb(), 0, ex(0, P_MRD, 0, 2'b00, 2'b00, 0));
    gen_instr(OP_LD, 0, 0, 0, 1);
    run_q("store_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
